// File: rtl/i2s_dual_clk.sv
// -----------------------------------------------------------------------------
// i2s_dual_clk
//
// Purpose
//   Produces the I2S bit clock, word select and frame position used by the
//   audio DSP datapath. An internal generator free-runs from ck. When a
//   well-formed external I2S master is seen on ext_sck/ext_ws (two
//   consecutive frame starts exactly 64 bit clocks apart), the outputs switch
//   over to that master. If the master stops toggling, or sends a frame of
//   the wrong length, the outputs fall back to the internal generator.
//
// Ports
//   ck          system clock, all logic on its rising edge
//   rst         synchronous, active-high reset
//   ext_sck     external I2S bit clock (asynchronous to ck)
//   ext_ws      external I2S word select (asynchronous to ck)
//   sck         selected bit clock
//   ws          selected word select (0 = left, 1 = right)
//   en          one-ck strobe on each selected sck rising edge
//   frame_posn  bit index within the 64-bit frame, 0 = first bit after ws falls
//   external    1 while the outputs come from the external master
// -----------------------------------------------------------------------------
module i2s_dual_clk #(
    parameter int DIVIDER = 16,
    parameter int TIMEOUT = 4 * DIVIDER
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       ext_sck,
    input  logic       ext_ws,
    output logic       sck,
    output logic       ws,
    output logic       en,
    output logic [5:0] frame_posn,
    output logic       external
);

    localparam int DIV_W = $clog2(DIVIDER);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DIVIDER - 1);
    localparam logic [DIV_W-1:0] DIV_HALF    = DIV_W'(DIVIDER / 2);
    localparam logic [WD_W-1:0]  WD_LIMIT    = WD_W'(TIMEOUT);
    localparam logic [6:0]       FRAME_EDGES = 7'd64;
    localparam logic [6:0]       EDGE_SAT    = 7'd127;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        COUNT  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    // ------------------------------------------------------------------
    // Synchronizers. Deliberately left out of reset: clearing them would
    // fabricate an edge on the first cycles after reset whenever the
    // external clock happens to be high.
    // ------------------------------------------------------------------
    logic sck_s1_q, sck_s2_q, sck_s3_q;
    logic ws_s1_q, ws_s2_q;

    always_ff @(posedge ck) begin
        sck_s1_q <= ext_sck;
        sck_s2_q <= sck_s1_q;
        sck_s3_q <= sck_s2_q;   // previous synced value, for edge detection
        ws_s1_q  <= ext_ws;
        ws_s2_q  <= ws_s1_q;
    end

    logic ext_rise, ext_fall;
    assign ext_rise = sck_s2_q & ~sck_s3_q;
    assign ext_fall = ~sck_s2_q & sck_s3_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q, div_d;
    logic [5:0]       posn_int_q, posn_int_d;
    logic [5:0]       posn_ext_q, posn_ext_d;
    logic             ws_at_fall_q, ws_at_fall_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [6:0]       edge_cnt_q;
    lock_state_t      state_q;
    logic             external_q;
    logic             sck_q, sck_d;
    logic             ws_q, ws_d;
    logic             en_q, en_d;
    logic [5:0]       posn_q, posn_d;

    // Internal generator view
    logic sck_int, en_int, ws_int, div_wrap;
    assign sck_int  = (div_q >= DIV_HALF);
    assign en_int   = (div_q == DIV_HALF);
    assign ws_int   = posn_int_q[5];
    assign div_wrap = (div_q == DIV_LAST);

    // Frame start: ws seen low at a falling edge after being high at the
    // previous falling edge.
    logic frame_start, frame_good, timeout;
    assign frame_start = ext_fall & ~ws_s2_q & ws_at_fall_q;
    assign frame_good  = (edge_cnt_q == FRAME_EDGES);
    assign timeout     = (wd_q == WD_LIMIT);

    // Lock status as it will be after this edge; drives the output mux so
    // that the switch-over cycle already shows the external frame start.
    // Timeout takes priority over a coincident frame start.
    logic ext_next;
    always_comb begin
        ext_next = 1'b0;
        if (!timeout) begin
            case (state_q)
                COUNT:   ext_next = frame_start & frame_good;
                LOCKED:  ext_next = ~(frame_start & ~frame_good);
                default: ext_next = 1'b0;
            endcase
        end
    end

    always_comb begin
        // Internal generator
        div_d      = div_wrap ? '0 : div_q + DIV_W'(1);
        posn_int_d = div_wrap ? posn_int_q + 6'd1 : posn_int_q;
        // Keep the internal phase aligned to the master so a fallback
        // continues close to where the external frame was.
        if (ext_next && frame_start) begin
            div_d      = '0;
            posn_int_d = '0;
        end

        // External bit position
        posn_ext_d = posn_ext_q;
        if (frame_start) begin
            posn_ext_d = '0;
        end else if (ext_fall) begin
            posn_ext_d = posn_ext_q + 6'd1;
        end

        ws_at_fall_d = ext_fall ? ws_s2_q : ws_at_fall_q;

        // Watchdog saturates at the limit so timeout stays asserted
        if (ext_rise) begin
            wd_d = '0;
        end else if (timeout) begin
            wd_d = wd_q;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end

        // Output mux: exactly one source per cycle, so at most one en
        if (ext_next) begin
            sck_d  = sck_s2_q;
            ws_d   = ws_s2_q;
            en_d   = ext_rise;
            posn_d = posn_ext_d;
        end else begin
            sck_d  = sck_int;
            ws_d   = ws_int;
            en_d   = en_int;
            posn_d = posn_int_q;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            div_q        <= '0;
            posn_int_q   <= '0;
            posn_ext_q   <= '0;
            ws_at_fall_q <= 1'b0;
            wd_q         <= '0;
            sck_q        <= 1'b0;
            ws_q         <= 1'b0;
            en_q         <= 1'b0;
            posn_q       <= '0;
        end else begin
            div_q        <= div_d;
            posn_int_q   <= posn_int_d;
            posn_ext_q   <= posn_ext_d;
            ws_at_fall_q <= ws_at_fall_d;
            wd_q         <= wd_d;
            sck_q        <= sck_d;
            ws_q         <= ws_d;
            en_q         <= en_d;
            posn_q       <= posn_d;
        end
    end

    // ------------------------------------------------------------------
    // Lock qualification FSM. edge_cnt_q counts synced ext_sck rising
    // edges since the last frame start; it saturates so a long gap can
    // never wrap back onto a valid frame length.
    // ------------------------------------------------------------------
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q    <= HUNT;
            edge_cnt_q <= '0;
            external_q <= 1'b0;
        end else begin
            external_q <= ext_next;
            if (timeout) begin
                state_q    <= HUNT;
                edge_cnt_q <= '0;
            end else if (frame_start) begin
                edge_cnt_q <= '0;
                case (state_q)
                    HUNT:    state_q <= COUNT;
                    COUNT:   state_q <= frame_good ? LOCKED : COUNT;
                    LOCKED:  state_q <= frame_good ? LOCKED : COUNT;
                    default: state_q <= HUNT;
                endcase
            end else if (ext_rise && edge_cnt_q != EDGE_SAT) begin
                edge_cnt_q <= edge_cnt_q + 7'd1;
            end
        end
    end

    assign sck        = sck_q;
    assign ws         = ws_q;
    assign en         = en_q;
    assign frame_posn = posn_q;
    assign external   = external_q;

endmodule

// File: tb/tb_i2s_dual_clk.sv
// -----------------------------------------------------------------------------
// tb_i2s_dual_clk
//
// Drives a behavioural I2S master (random start phase, programmable frame
// length) and compares every output cycle against a reference model:
//   - internal mode: sck/en/ws/frame_posn computed arithmetically from the
//     number of cycles since the last alignment point (reset or a locked
//     external frame start);
//   - external mode: the master's own sck/ws/bit index delayed through the
//     two synchronizer stages;
//   - lock status: locked when the last completed frame (between two frame
//     starts seen since the last watchdog expiry/reset) held 64 bit clocks.
// Directed phases then check the headline behaviours with bounded waits.
// -----------------------------------------------------------------------------
module tb_i2s_dual_clk;

    localparam int DIV      = 16;
    localparam int TMO      = 4 * DIV;
    localparam int FRAME_CK = 64 * DIV;

    logic       ck      = 1'b0;
    logic       rst     = 1'b1;
    logic       ext_sck = 1'b0;
    logic       ext_ws  = 1'b0;
    logic       sck, ws, en, external;
    logic [5:0] frame_posn;

    i2s_dual_clk #(
        .DIVIDER(DIV),
        .TIMEOUT(TMO)
    ) dut (
        .ck        (ck),
        .rst       (rst),
        .ext_sck   (ext_sck),
        .ext_ws    (ext_ws),
        .sck       (sck),
        .ws        (ws),
        .en        (en),
        .frame_posn(frame_posn),
        .external  (external)
    );

    always #5 ck = ~ck;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // ------------------------------------------------------------------
    // External I2S master, updated on the falling edge of ck
    // ------------------------------------------------------------------
    logic m_on       = 1'b0;
    int   seed_ph    = 0;
    int   seed_b     = 0;
    int   m_next_len = 64;
    int   m_ph       = 0;
    int   m_b        = 0;
    int   m_len      = 64;
    bit   m_running  = 1'b0;

    initial begin : master
        forever begin
            @(negedge ck);
            if (m_on) begin
                if (!m_running) begin
                    m_running = 1'b1;
                    m_ph      = seed_ph;
                    m_b       = seed_b;
                    m_len     = 64;
                end else begin
                    m_ph = (m_ph + 1) % DIV;
                    if (m_ph == 0) begin
                        if (m_b + 1 >= m_len) begin
                            m_b   = 0;
                            m_len = m_next_len;
                        end else begin
                            m_b = m_b + 1;
                        end
                    end
                end
                ext_sck = (m_ph >= DIV / 2);
                ext_ws  = (m_b >= m_len / 2);
            end else begin
                m_running = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model and per-cycle output comparison
    // ------------------------------------------------------------------
    initial begin : monitor
        logic [3:0] hsk;
        logic [3:0] hws;
        int         hb [4];
        int         cyc, anchor, last_rise, nfs, ecnt;
        bit         m_ext, last_fall_ws;
        bit         rise, fall, fs, tmo;
        int         m, p, q;
        logic [9:0] exp;
        hsk = '0; hws = '0;
        for (int i = 0; i < 4; i++) hb[i] = 0;
        cyc = 0; anchor = 0; last_rise = 0; nfs = 0; ecnt = 0;
        m_ext = 1'b0; last_fall_ws = 1'b0;
        forever begin
            @(posedge ck);
            cyc++;
            hsk   = {hsk[2:0], ext_sck};
            hws   = {hws[2:0], ext_ws};
            hb[3] = hb[2]; hb[2] = hb[1]; hb[1] = hb[0]; hb[0] = m_b;
            if (rst) begin
                anchor = cyc; last_rise = cyc; nfs = 0; ecnt = 0;
                m_ext = 1'b0; last_fall_ws = 1'b0;
                exp = '0;
            end else begin
                // events as seen after the two-stage synchronizer
                rise = hsk[2] & ~hsk[3];
                fall = ~hsk[2] & hsk[3];
                tmo  = (cyc - last_rise) > TMO;
                if (rise) last_rise = cyc;
                fs = fall && !hws[2] && last_fall_ws;
                if (fall) last_fall_ws = hws[2];
                if (tmo) begin
                    nfs   = 0;
                    m_ext = 1'b0;
                end else if (fs) begin
                    if (nfs == 0) begin
                        nfs   = 1;
                        m_ext = 1'b0;
                    end else begin
                        m_ext = (ecnt == 64);
                    end
                    ecnt = 0;
                end else if (rise) begin
                    ecnt++;
                end
                if (fs && m_ext) anchor = cyc;
                if (m_ext) begin
                    exp = {1'b1, hsk[2], hws[2], rise, 6'(hb[2])};
                end else begin
                    m   = cyc - anchor;
                    p   = (m - 1) % DIV;
                    q   = ((m - 1) / DIV) % 64;
                    exp = {1'b0, (p >= DIV / 2), (q >= 32), (p == DIV / 2), 6'(q)};
                end
            end
            #1;
            check_eq("outputs", 32'({external, sck, ws, en, frame_posn}), 32'(exp));
        end
    end

    // ------------------------------------------------------------------
    // Directed phases
    // ------------------------------------------------------------------
    initial begin : main
        int   cnt, falls, ext_hi, waited;
        logic prev_ws;

        rst = 1'b1;
        repeat (4) tick();
        check_eq("t1_reset_outputs", 32'({external, sck, ws, en, frame_posn}), 32'd0);
        rst = 1'b0;

        // 1: internal generator only
        repeat (200) tick();
        cnt = 0; falls = 0; ext_hi = 0; prev_ws = ws;
        repeat (FRAME_CK) begin
            tick();
            if (en) cnt++;
            if (prev_ws && !ws) falls++;
            if (external) ext_hi++;
            prev_ws = ws;
        end
        check_eq("t1_en_per_frame", 32'(cnt), 32'd64);
        check_eq("t1_ws_falls_per_1024", 32'(falls), 32'd1);
        check_eq("t1_external_low", 32'(ext_hi), 32'd0);
        $display("[t1] internal: en=%0d ws_falls=%0d external_cycles=%0d", cnt, falls, ext_hi);

        // 2: enable master at a random phase
        repeat ($urandom_range(1, 500)) tick();
        seed_ph = $urandom_range(0, DIV - 1);
        seed_b  = $urandom_range(0, 63);
        m_next_len = 64;
        m_on = 1'b1;
        tick();
        check_eq("t2_not_yet_external", 32'(external), 32'd0);
        waited = 0;
        while (!external && waited < 3 * FRAME_CK) begin
            tick();
            waited++;
        end
        check_eq("t2_locked", 32'(external), 32'd1);
        check_eq("t2_lock_posn", 32'(frame_posn), 32'd0);
        check_eq("t2_lock_ws", 32'(ws), 32'd0);
        $display("[t2] master ph=%0d b=%0d locked after %0d cycles", seed_ph, seed_b, waited);

        // 3: stay locked
        cnt = 0;
        repeat (2 * FRAME_CK) begin
            tick();
            if (external) cnt++;
        end
        check_eq("t3_stays_locked", 32'(cnt), 32'(2 * FRAME_CK));
        $display("[t3] locked cycles=%0d", cnt);

        // 4: master stops
        m_on = 1'b0;
        waited = 0;
        while (external && waited < TMO + 3) begin
            tick();
            waited++;
        end
        check_eq("t4_fallback", 32'(external), 32'd0);
        falls = 0; ext_hi = 0; prev_ws = ws;
        repeat (3 * FRAME_CK) begin
            tick();
            if (prev_ws && !ws) falls++;
            if (external) ext_hi++;
            prev_ws = ws;
        end
        check_eq("t4_internal_ws_falls", 32'(falls), 32'd3);
        check_eq("t4_stays_internal", 32'(ext_hi), 32'd0);
        $display("[t4] fallback after %0d cycles, ws_falls=%0d", waited, falls);

        // 5: one 62-bit frame while locked
        seed_ph = $urandom_range(0, DIV - 1);
        seed_b  = $urandom_range(0, 63);
        m_on = 1'b1;
        waited = 0;
        while (!external && waited < 3 * FRAME_CK) begin
            tick();
            waited++;
        end
        check_eq("t5_locked", 32'(external), 32'd1);
        repeat ($urandom_range(0, 500)) tick();
        m_next_len = 62;
        waited = 0;
        while (m_len != 62 && waited < FRAME_CK + DIV) begin
            tick();
            waited++;
        end
        m_next_len = 64;
        waited = 0;
        while (external && waited < FRAME_CK + 64) begin
            tick();
            waited++;
        end
        check_eq("t5_drop_on_short", 32'(external), 32'd0);
        waited = 0;
        while (!external && waited < 2 * FRAME_CK + 64) begin
            tick();
            waited++;
        end
        check_eq("t5_relock", 32'(external), 32'd1);
        $display("[t5] relocked %0d cycles after short frame", waited);

        // 6: reset mid-frame while locked
        repeat ($urandom_range(50, 900)) tick();
        rst = 1'b1;
        tick();
        check_eq("t6_reset_outputs", 32'({external, sck, ws, en, frame_posn}), 32'd0);
        tick();
        rst = 1'b0;
        waited = 0;
        while (!external && waited < 3 * FRAME_CK) begin
            tick();
            waited++;
        end
        check_eq("t6_requalified", 32'(external), 32'd1);
        check_eq("t6_full_qualification", 32'(waited >= FRAME_CK), 32'd1);
        $display("[t6] relock after reset took %0d cycles", waited);

        m_on = 1'b0;
        repeat (20) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
